// File: rtl/sn_pkg.sv
// +--------------------------------------------------------------------------+
// | sn_pkg : shared op encoding for the sn ring, its tiles and its scheduler  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package sn_pkg;

    localparam int SN_OP_W = 2;

    typedef enum logic [SN_OP_W-1:0] {
        SN_OP_NOP   = 2'd0,
        SN_OP_LOAD  = 2'd1,
        SN_OP_START = 2'd2,
        SN_OP_STOP  = 2'd3
    } sn_op_e;

endpackage : sn_pkg

`default_nettype wire

// File: rtl/sn_rr_arb.sv
// +--------------------------------------------------------------------------+
// | sn_rr_arb : combinational round-robin arbiter, search starts at rr_ptr    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module sn_rr_arb #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest offset back to rr_ptr so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        if (enable) begin
            for (int off = NUM_REQ - 1; off >= 0; off--) begin
                idx = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                end
            end
        end
    end

endmodule : sn_rr_arb

`default_nettype wire

// File: rtl/sn_ring_sched.sv
// +--------------------------------------------------------------------------+
// | sn_ring_sched : sole sequencer of the sn ring; arbitrates requesters and  |
// | keeps one ring command outstanding with a timeout. Revision: 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module sn_ring_sched
    import sn_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TILE_WIDTH     = 4,
    parameter  int ADDR_WIDTH     = 64,
    parameter  int WL_LEN_BITS    = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*SN_OP_W-1:0]     req_op,
    input  logic [NUM_REQ*TILE_WIDTH-1:0]  req_tile,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*WL_LEN_BITS-1:0] req_len,
    output logic [SN_OP_W-1:0]             ring_op,
    output logic [TILE_WIDTH-1:0]          ring_tile,
    output logic [ADDR_WIDTH-1:0]          ring_addr,
    output logic [WL_LEN_BITS-1:0]         ring_len,
    input  logic                           ring_ack,
    input  logic                           ring_done,
    output logic                           resp_valid,
    output logic [IDX_W-1:0]               resp_id,
    output logic                           resp_err,
    output logic                           busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DRIVE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_RESP      = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       id_q, id_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    sn_op_e                 ring_op_q, ring_op_d;
    logic [TILE_WIDTH-1:0]  ring_tile_q, ring_tile_d;
    logic [ADDR_WIDTH-1:0]  ring_addr_q, ring_addr_d;
    logic [WL_LEN_BITS-1:0] ring_len_q, ring_len_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [IDX_W-1:0]       resp_id_q, resp_id_d;
    logic                   resp_err_q, resp_err_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   accept;
    logic                   timeout_hit;
    logic                   err_d;
    sn_op_e                 sel_op;

    sn_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .enable    (state_q == ST_IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready   = grant;
    assign accept      = |grant;
    assign sel_op      = sn_op_e'(req_op[grant_idx*SN_OP_W +: SN_OP_W]);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A terminating ack/done takes priority over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (sel_op == SN_OP_NOP) ? ST_RESP : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (ring_ack) begin
                    state_d = ring_done ? ST_RESP : ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT_DONE: begin
                if (ring_done || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_d = 1'b0;
        case (state_q)
            ST_IDLE:      err_d = (sel_op == SN_OP_NOP);
            ST_DRIVE:     err_d = !ring_ack && timeout_hit;
            ST_WAIT_DONE: err_d = !ring_done && timeout_hit;
            default:      err_d = 1'b0;
        endcase

        id_d        = accept ? grant_idx : id_q;
        ring_tile_d = ring_tile_q;
        ring_addr_d = ring_addr_q;
        ring_len_d  = ring_len_q;
        // NOP requests never reach the ring, so only a real issue loads the bus.
        if (state_q == ST_IDLE && state_d == ST_DRIVE) begin
            ring_tile_d = req_tile[grant_idx*TILE_WIDTH +: TILE_WIDTH];
            ring_addr_d = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ring_len_d  = req_len[grant_idx*WL_LEN_BITS +: WL_LEN_BITS];
        end
        ring_op_d = SN_OP_NOP;
        if (state_d == ST_DRIVE) begin
            ring_op_d = (state_q == ST_IDLE) ? sel_op : ring_op_q;
        end

        cnt_d = '0;
        if (state_q == ST_DRIVE || state_q == ST_WAIT_DONE) begin
            cnt_d = cnt_q + 1'b1;
        end

        rr_ptr_d = rr_ptr_q;
        if (state_q == ST_RESP) begin
            rr_ptr_d = (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end

        resp_valid_d = (state_d == ST_RESP);
        resp_id_d    = (state_d == ST_RESP) ? id_d : '0;
        resp_err_d   = (state_d == ST_RESP) && err_d;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            ring_op_q    <= SN_OP_NOP;
            ring_tile_q  <= '0;
            ring_addr_q  <= '0;
            ring_len_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            ring_op_q    <= ring_op_d;
            ring_tile_q  <= ring_tile_d;
            ring_addr_q  <= ring_addr_d;
            ring_len_q   <= ring_len_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign ring_op    = ring_op_q;
    assign ring_tile  = ring_tile_q;
    assign ring_addr  = ring_addr_q;
    assign ring_len   = ring_len_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule : sn_ring_sched

`default_nettype wire

// File: tb/tb_sn_ring_sched.sv
// +--------------------------------------------------------------------------+
// | tb_sn_ring_sched : directed self-checking bench for sn_ring_sched         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sn_ring_sched;
    import sn_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TW      = 4;
    localparam int AW      = 64;
    localparam int LW      = 32;
    localparam int IDX_W   = $clog2(NUM_REQ);

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*SN_OP_W-1:0] req_op = '0;
    logic [NUM_REQ*TW-1:0]   req_tile = '0;
    logic [NUM_REQ*AW-1:0]   req_addr = '0;
    logic [NUM_REQ*LW-1:0]   req_len = '0;
    logic [SN_OP_W-1:0]      ring_op;
    logic [TW-1:0]           ring_tile;
    logic [AW-1:0]           ring_addr;
    logic [LW-1:0]           ring_len;
    logic                    ring_ack = 1'b0;
    logic                    ring_done = 1'b0;
    logic                    resp_valid;
    logic [IDX_W-1:0]        resp_id;
    logic                    resp_err;
    logic                    busy;

    int n_chk  = 0;
    int n_fail = 0;

    sn_ring_sched #(
        .NUM_REQ        (NUM_REQ),
        .TILE_WIDTH     (TW),
        .ADDR_WIDTH     (AW),
        .WL_LEN_BITS    (LW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_tile   (req_tile),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .ring_op    (ring_op),
        .ring_tile  (ring_tile),
        .ring_addr  (ring_addr),
        .ring_len   (ring_len),
        .ring_ack   (ring_ack),
        .ring_done  (ring_done),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input sn_op_e op, input logic [TW-1:0] tile,
                           input logic [AW-1:0] addr, input logic [LW-1:0] len);
        req_op[i*SN_OP_W +: SN_OP_W] = op;
        req_tile[i*TW +: TW]         = tile;
        req_addr[i*AW +: AW]         = addr;
        req_len[i*LW +: LW]          = len;
    endtask

    initial begin
        // Reset state
        tick(); tick(); settle();
        chk("rst_ring_op", 64'(ring_op), 64'(SN_OP_NOP));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_ring_addr", ring_addr, 64'd0);
        rst = 1'b0;

        // Single command: accept at cycle 0, ack at 3, done at 7
        tick();
        set_req(0, SN_OP_LOAD, 4'd3, 64'h1000, 32'd16);
        req_valid = 4'b0001;
        settle();
        chk("single_ready", 64'(req_ready), 64'h1);
        tick(); req_valid = '0; settle();                         // cycle 1
        chk("single_op_c1", 64'(ring_op), 64'(SN_OP_LOAD));
        chk("single_tile", 64'(ring_tile), 64'd3);
        chk("single_addr", ring_addr, 64'h1000);
        chk("single_len", 64'(ring_len), 64'd16);
        chk("single_busy", 64'(busy), 64'd1);
        tick(); settle();                                         // cycle 2
        chk("single_op_c2", 64'(ring_op), 64'(SN_OP_LOAD));
        tick(); ring_ack = 1'b1; settle();                        // cycle 3
        chk("single_op_c3", 64'(ring_op), 64'(SN_OP_LOAD));
        tick(); ring_ack = 1'b0; settle();                        // cycle 4
        chk("single_op_c4", 64'(ring_op), 64'(SN_OP_NOP));
        tick(); tick(); tick(); ring_done = 1'b1; settle();       // cycle 7
        chk("single_no_early_resp", 64'(resp_valid), 64'd0);
        tick(); ring_done = 1'b0; settle();                       // cycle 8
        chk("single_resp_valid", 64'(resp_valid), 64'd1);
        chk("single_resp_id", 64'(resp_id), 64'd0);
        chk("single_resp_err", 64'(resp_err), 64'd0);
        tick(); settle();                                         // cycle 9
        chk("single_resp_pulse", 64'(resp_valid), 64'd0);
        chk("single_idle", 64'(busy), 64'd0);

        // Stray done while idle, then a NOP request from requester 2
        ring_done = 1'b1;
        tick(); ring_done = 1'b0; settle();
        chk("stray_done_resp", 64'(resp_valid), 64'd0);
        chk("stray_done_busy", 64'(busy), 64'd0);
        set_req(2, SN_OP_NOP, 4'd7, 64'hdead, 32'd5);
        req_valid = 4'b0100;
        settle();
        chk("nop_ready", 64'(req_ready), 64'h4);
        tick(); req_valid = '0; settle();
        chk("nop_resp_valid", 64'(resp_valid), 64'd1);
        chk("nop_resp_id", 64'(resp_id), 64'd2);
        chk("nop_resp_err", 64'(resp_err), 64'd1);
        chk("nop_ring_op", 64'(ring_op), 64'(SN_OP_NOP));
        chk("nop_ring_addr", ring_addr, 64'h1000);
        tick(); settle();

        // Timeout: rr_ptr=3, only requester 1 valid; never acked
        set_req(1, SN_OP_START, 4'd5, 64'h2000, 32'd8);
        req_valid = 4'b0010;
        settle();
        chk("to_ready", 64'(req_ready), 64'h2);
        tick(); req_valid = '0; settle();                         // DRIVE cycle 1
        chk("to_op_c1", 64'(ring_op), 64'(SN_OP_START));
        for (int c = 2; c <= 8; c++) tick();
        settle();                                                 // cycle 8
        chk("to_op_c8", 64'(ring_op), 64'(SN_OP_START));
        chk("to_no_resp_c8", 64'(resp_valid), 64'd0);
        tick(); settle();                                         // cycle 9
        chk("to_resp_valid", 64'(resp_valid), 64'd1);
        chk("to_resp_err", 64'(resp_err), 64'd1);
        chk("to_resp_id", 64'(resp_id), 64'd1);
        chk("to_op_nop", 64'(ring_op), 64'(SN_OP_NOP));
        tick(); ring_ack = 1'b1; settle();                        // late ack
        tick(); ring_ack = 1'b0; settle();
        chk("late_ack_resp", 64'(resp_valid), 64'd0);
        chk("late_ack_busy", 64'(busy), 64'd0);
        chk("late_ack_op", 64'(ring_op), 64'(SN_OP_NOP));

        // Reset while in WAIT_DONE: rr_ptr=2, requester 3 wins
        set_req(3, SN_OP_STOP, 4'd9, 64'h3000, 32'd4);
        req_valid = 4'b1000;
        settle();
        chk("rst_mid_ready", 64'(req_ready), 64'h8);
        tick(); req_valid = '0; ring_ack = 1'b1; settle();        // DRIVE
        chk("rst_mid_op", 64'(ring_op), 64'(SN_OP_STOP));
        tick(); ring_ack = 1'b0; settle();                        // WAIT_DONE
        chk("rst_mid_wait_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_op_nop", 64'(ring_op), 64'(SN_OP_NOP));
        chk("rst_mid_busy", 64'(busy), 64'd0);
        tick(); rst = 1'b0;

        // Round robin: all valid, ack+done one cycle after issue
        for (int i = 0; i < NUM_REQ; i++)
            set_req(i, SN_OP_LOAD, 4'(i + 4), 64'(32'h100 * (i + 1)), 32'(i + 1));
        req_valid = 4'b1111;
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            for (int k = 0; k < 5; k++) begin
                settle();
                chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(1) << order[k]);
                tick(); settle();
                chk($sformatf("rr_tile_%0d", k), 64'(ring_tile), 64'(order[k] + 4));
                tick(); ring_ack = 1'b1; ring_done = 1'b1;
                tick(); ring_ack = 1'b0; ring_done = 1'b0; settle();
                chk($sformatf("rr_resp_id_%0d", k), 64'(resp_id), 64'(order[k]));
                chk($sformatf("rr_resp_valid_%0d", k), 64'(resp_valid), 64'd1);
                tick();
            end
        end
        req_valid = '0;

        // Same-cycle ack+done in the first DRIVE cycle: rr_ptr=1
        set_req(1, SN_OP_LOAD, 4'd2, 64'h4000, 32'd1);
        req_valid = 4'b0010;
        settle();
        chk("same_ready", 64'(req_ready), 64'h2);
        tick(); req_valid = '0; ring_ack = 1'b1; ring_done = 1'b1; settle();
        chk("same_op", 64'(ring_op), 64'(SN_OP_LOAD));
        tick(); ring_ack = 1'b0; ring_done = 1'b0; settle();
        chk("same_resp_valid", 64'(resp_valid), 64'd1);
        chk("same_resp_err", 64'(resp_err), 64'd0);
        chk("same_resp_id", 64'(resp_id), 64'd1);
        chk("same_op_nop", 64'(ring_op), 64'(SN_OP_NOP));
        tick(); settle();
        chk("same_idle", 64'(busy), 64'd0);
        chk("same_pulse", 64'(resp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_sn_ring_sched

`default_nettype wire
